stream_transpose_buf: RTL and testbench

- Registered, fully pipelined N x N coefficient transpose on a nasti stream.
- Input: one matrix row per beat. Output: one matrix column per beat.
- Ping-pong banks sustain one beat per cycle each side. Full t_valid/t_ready backpressure.
- Generalised successor to the fixed 8x8 combinational transpose. Sits between the row and column 1-D transform stages of the 2-D DCT/IDCT pipeline.

---
 rtl/stream_transpose_buf_if.sv | 30 +++
 rtl/stream_transpose_buf.sv | 146 ++++++++++++++
 tb/tb_stream_transpose_buf.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_transpose_buf_if.sv
// nasti stream channel: one beat per valid/ready handshake, with the usual
// keep/strb/last/id/dest/user sideband.
interface nasti_stream_channel #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 4
);
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    logic                  t_valid;
    logic                  t_ready;
    logic [DATA_WIDTH-1:0] t_data;
    logic [STRB_WIDTH-1:0] t_strb;
    logic [STRB_WIDTH-1:0] t_keep;
    logic                  t_last;
    logic [ID_WIDTH-1:0]   t_id;
    logic [DEST_WIDTH-1:0] t_dest;
    logic [USER_WIDTH-1:0] t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/stream_transpose_buf.sv
// Registered N x N transpose: rows in, columns out, through two ping-pong register banks.
// Define STREAM_TRANSPOSE_LAST_CHECK_EN to add input t_last framing check and the sticky err port.
module stream_transpose_buf #(
    parameter int COEF_WIDTH = 16,
    parameter int N          = 8,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 4
) (
    input  logic                aclk,
    input  logic                areset,
    nasti_stream_channel.slave  in_ch,
    nasti_stream_channel.master out_ch
`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
    ,
    output logic                err
`endif
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [COEF_WIDTH-1:0] bank_mem [2][N][N];
    logic [ID_WIDTH-1:0]   id_mem   [2];
    logic [DEST_WIDTH-1:0] dest_mem [2];
    logic [USER_WIDTH-1:0] user_mem [2];

    logic             wr_sel_reg;
    logic             rd_sel_reg;
    logic [IDX_W-1:0] wr_row_reg;
    logic [IDX_W-1:0] rd_col_reg;
    logic [1:0]       full_reg;

    logic in_fire;
    logic out_fire;
    logic wr_done;
    logic rd_done;

    logic [COEF_WIDTH-1:0] row_lane [N];
    logic [COEF_WIDTH-1:0] col_lane [N];
    logic [DATA_WIDTH-1:0] out_data;

    assign in_ch.t_ready = !full_reg[wr_sel_reg] && !areset;
    assign in_fire       = in_ch.t_valid && in_ch.t_ready;
    assign out_fire      = out_ch.t_valid && out_ch.t_ready;
    assign rd_done       = out_fire && (rd_col_reg == LAST_IDX);

`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
    // An early t_last closes the bank so the next beat starts a fresh block.
    assign wr_done = in_fire && ((wr_row_reg == LAST_IDX) || in_ch.t_last);
`else
    assign wr_done = in_fire && (wr_row_reg == LAST_IDX);
`endif

    // Lane slicing on both sides; the read mux is a plain select off registers.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign row_lane[gi] = in_ch.t_data[gi*COEF_WIDTH +: COEF_WIDTH];
            assign col_lane[gi] = bank_mem[rd_sel_reg][gi][rd_col_reg];
        end
    endgenerate

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            out_data[i*COEF_WIDTH +: COEF_WIDTH] = col_lane[i];
        end
    end

    // Bank contents and sideband carry no reset; the full flags gate their use.
    always_ff @(posedge aclk) begin
        if (in_fire) begin
            for (int j = 0; j < N; j++) begin
                bank_mem[wr_sel_reg][wr_row_reg][j] <= row_lane[j];
            end
            if (wr_row_reg == '0) begin
                id_mem[wr_sel_reg]   <= in_ch.t_id;
                dest_mem[wr_sel_reg] <= in_ch.t_dest;
                user_mem[wr_sel_reg] <= in_ch.t_user;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_sel_reg <= 1'b0;
            rd_sel_reg <= 1'b0;
            wr_row_reg <= '0;
            rd_col_reg <= '0;
            full_reg   <= 2'b00;
        end else begin
            if (in_fire) begin
                if (wr_done) begin
                    wr_sel_reg <= !wr_sel_reg;
                    wr_row_reg <= '0;
                end else begin
                    wr_row_reg <= wr_row_reg + 1'b1;
                end
            end
            if (out_fire) begin
                if (rd_done) begin
                    rd_sel_reg <= !rd_sel_reg;
                    rd_col_reg <= '0;
                end else begin
                    rd_col_reg <= rd_col_reg + 1'b1;
                end
            end
            // The interlock keeps write and read on different banks, so both may land at once.
            for (int b = 0; b < 2; b++) begin
                if (wr_done && (wr_sel_reg == 1'(b))) begin
                    full_reg[b] <= 1'b1;
                end else if (rd_done && (rd_sel_reg == 1'(b))) begin
                    full_reg[b] <= 1'b0;
                end
            end
        end
    end

    assign out_ch.t_valid = full_reg[rd_sel_reg] && !areset;
    assign out_ch.t_last  = (rd_col_reg == LAST_IDX) && !areset;
    assign out_ch.t_data  = out_data;
    assign out_ch.t_keep  = '1;
    assign out_ch.t_strb  = '1;
    assign out_ch.t_id    = id_mem[rd_sel_reg];
    assign out_ch.t_dest  = dest_mem[rd_sel_reg];
    assign out_ch.t_user  = user_mem[rd_sel_reg];

`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
    logic err_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_reg <= 1'b0;
        end else if (in_fire && (in_ch.t_last != (wr_row_reg == LAST_IDX))) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

    // Input keep/strb (and t_last unless checked) plus any t_data bits above the lanes are don't-care.
    logic unused_in_bits;
    assign unused_in_bits = ^{in_ch.t_keep, in_ch.t_strb, in_ch.t_last, in_ch.t_data};
endmodule

// File: tb/tb_stream_transpose_buf.sv
// Self-checking bench for stream_transpose_buf: a queue-based transpose model fed by the
// observed input handshakes is compared against the observed output beats.
module tb_stream_transpose_buf;
    localparam int N  = 8;
    localparam int CW = 16;
    localparam int DW = N * CW;
    localparam int SW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [3:0]    id;
        logic [3:0]    dest;
        logic [3:0]    user;
        int            cyc;
    } beat_t;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    int   tests      = 0;
    int   fails      = 0;
    int   cyc        = 0;
    int   acc_cnt    = 0;
    int   stall_seen = 0;
    int   rdy_mode   = 0;

    beat_t         exp_q[$];
    beat_t         obs_q[$];
    beat_t         mon_b;
    logic [DW-1:0] rows [N];
    int            row_cnt = 0;
    logic [3:0]    blk_id;
    logic [3:0]    blk_dest;
    logic [3:0]    blk_user;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    nasti_stream_channel #(.DATA_WIDTH(DW), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)) in_ch ();
    nasti_stream_channel #(.DATA_WIDTH(DW), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)) out_ch ();

`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
    logic err8;
`endif

    stream_transpose_buf #(
        .COEF_WIDTH(CW), .N(N), .DATA_WIDTH(DW), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .in_ch  (in_ch),
        .out_ch (out_ch)
`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
        ,
        .err    (err8)
`endif
    );

`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
    localparam int N4  = 4;
    localparam int CW4 = 12;
    localparam int DW4 = N4 * CW4;
    logic err4;
    nasti_stream_channel #(.DATA_WIDTH(DW4), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)) in4 ();
    nasti_stream_channel #(.DATA_WIDTH(DW4), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)) out4 ();
    stream_transpose_buf #(
        .COEF_WIDTH(CW4), .N(N4), .DATA_WIDTH(DW4), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)
    ) dut4 (
        .aclk   (aclk),
        .areset (areset),
        .in_ch  (in4),
        .out_ch (out4),
        .err    (err4)
    );
`endif

    // Output ready driver: 0 = held low, 1 = held high, 2 = coin toss each cycle.
    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       out_ch.t_ready = 1'b0;
            1:       out_ch.t_ready = 1'b1;
            default: out_ch.t_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: collect N accepted rows, emit their transpose as N expected beats.
    always @(negedge aclk) begin
        if (areset) begin
            row_cnt = 0;
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end else begin
            if (in_ch.t_valid && in_ch.t_ready) begin
                acc_cnt++;
                if (row_cnt == 0) begin
                    blk_id   = in_ch.t_id;
                    blk_dest = in_ch.t_dest;
                    blk_user = in_ch.t_user;
                end
                rows[row_cnt] = in_ch.t_data;
                row_cnt++;
                if (row_cnt == N) begin
                    for (int k = 0; k < N; k++) begin
                        mon_b.data = '0;
                        for (int i = 0; i < N; i++) mon_b.data[i*CW +: CW] = rows[i][k*CW +: CW];
                        mon_b.last = (k == N - 1);
                        mon_b.id   = blk_id;
                        mon_b.dest = blk_dest;
                        mon_b.user = blk_user;
                        mon_b.cyc  = cyc + 1 + k;
                        exp_q.push_back(mon_b);
                    end
                    row_cnt = 0;
                end
            end
            if (out_ch.t_valid && out_ch.t_ready) begin
                mon_b.data = out_ch.t_data;
                mon_b.last = out_ch.t_last;
                mon_b.id   = out_ch.t_id;
                mon_b.dest = out_ch.t_dest;
                mon_b.user = out_ch.t_user;
                mon_b.cyc  = cyc;
                obs_q.push_back(mon_b);
            end
        end
    end

    task automatic send_row(input logic [DW-1:0] d, input logic [3:0] id, input logic last,
                            input bit rand_idle);
        int n = 0;
        while (rand_idle && $urandom_range(0, 1) == 1) begin
            in_ch.t_valid = 1'b0;
            @(posedge aclk);
            #1;
        end
        in_ch.t_valid = 1'b1;
        in_ch.t_data  = d;
        in_ch.t_id    = id;
        in_ch.t_dest  = id ^ 4'h5;
        in_ch.t_user  = ~id;
        in_ch.t_last  = last;
        in_ch.t_keep  = SW'($urandom);
        in_ch.t_strb  = SW'($urandom);
        @(negedge aclk);
        while (!in_ch.t_ready && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        stall_seen += n;
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL send_row_timeout: t_ready stayed %b, required 1", in_ch.t_ready);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic send_block(input int mode, input bit rand_idle);
        logic [DW-1:0] d;
        logic [3:0]    id;
        id = 4'($urandom);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) d[c*CW +: CW] = (mode == 0) ? CW'(r * 16 + c) : CW'($urandom);
            send_row(d, id + 4'(r), r == N - 1, rand_idle);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        tests++; if (in_ch.t_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b required 0", in_ch.t_ready); end
        tests++; if (out_ch.t_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_ch.t_valid); end
        tests++; if (out_ch.t_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b required 0", out_ch.t_last); end
`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
        tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", err8); end
`endif
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        tests++; if (in_ch.t_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b required 1", in_ch.t_ready); end
        tests++; if (out_ch.t_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid: got %b required 0", out_ch.t_valid); end
        tests++; if (out_ch.t_last !== 1'b0) begin fails++; $display("FAIL post_reset_out_last: got %b required 0", out_ch.t_last); end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_single_block();
        beat_t         ob;
        beat_t         eb;
        logic [CW-1:0] lane;
        int            n;
        rdy_mode = 1;
        repeat (2) @(posedge aclk);
        #1;
        send_block(0, 1'b0);
        in_ch.t_valid = 1'b0;
        repeat (12) @(posedge aclk);
        #1;
        n = obs_q.size();
        tests++; if (n != N) begin fails++; $display("FAIL single_count: got %0d beats required %0d", n, N); end
        for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            ob = obs_q.pop_front();
            eb = exp_q.pop_front();
            tests++;
            if (ob.data !== eb.data || ob.id !== eb.id || ob.dest !== eb.dest || ob.user !== eb.user) begin
                fails++; $display("FAIL single_beat %0d: got %h id %h required %h id %h", k, ob.data, ob.id, eb.data, eb.id);
            end
            tests++; if (ob.cyc != eb.cyc) begin fails++; $display("FAIL single_latency %0d: got cycle %0d required %0d", k, ob.cyc, eb.cyc); end
            tests++; if (ob.last !== (k == N - 1)) begin fails++; $display("FAIL single_last %0d: got %b", k, ob.last); end
            lane = ob.data[(N-1)*CW +: CW];
            tests++; if (lane !== CW'((N - 1) * 16 + k)) begin fails++; $display("FAIL single_lane7 %0d: got %h required %h", k, lane, CW'((N - 1) * 16 + k)); end
        end
    endtask

    task automatic test_back_to_back();
        beat_t ob;
        beat_t eb;
        int    c0;
        int    n;
        rdy_mode = 1;
        repeat (2) @(posedge aclk);
        #1;
        stall_seen = 0;
        c0 = cyc;
        for (int b = 0; b < 3; b++) send_block(1, 1'b0);
        in_ch.t_valid = 1'b0;
        repeat (12) @(posedge aclk);
        #1;
        tests++; if (stall_seen != 0) begin fails++; $display("FAIL b2b_ready_drop: got %0d stalled cycles required 0", stall_seen); end
        n = obs_q.size();
        tests++; if (n != 3 * N) begin fails++; $display("FAIL b2b_count: got %0d beats required %0d", n, 3 * N); end
        for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            ob = obs_q.pop_front();
            eb = exp_q.pop_front();
            tests++;
            if (ob.data !== eb.data || ob.last !== eb.last || ob.id !== eb.id) begin
                fails++; $display("FAIL b2b_beat %0d: got %h last %b required %h last %b", k, ob.data, ob.last, eb.data, eb.last);
            end
            tests++; if (ob.cyc != c0 + N + k) begin fails++; $display("FAIL b2b_cycle %0d: got %0d required %0d", k, ob.cyc - c0, N + k); end
        end
    endtask

    task automatic test_backpressure();
        beat_t ob;
        beat_t eb;
        int    a0;
        int    n;
        rdy_mode = 0;
        repeat (2) @(posedge aclk);
        #1;
        a0 = acc_cnt;
        send_block(1, 1'b0);
        send_block(1, 1'b0);
        in_ch.t_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge aclk);
            tests++; if (in_ch.t_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready %0d: got %b required 0", s, in_ch.t_ready); end
            tests++;
            if (exp_q.size() == 0 || out_ch.t_valid !== 1'b1 || out_ch.t_data !== exp_q[0].data) begin
                fails++; $display("FAIL bp_hold %0d: valid %b data %h", s, out_ch.t_valid, out_ch.t_data);
            end
        end
        @(posedge aclk);
        #1;
        in_ch.t_valid = 1'b0;
        tests++; if (acc_cnt - a0 != 2 * N) begin fails++; $display("FAIL bp_accepted: got %0d required %0d", acc_cnt - a0, 2 * N); end
        rdy_mode = 1;
        repeat (30) @(posedge aclk);
        #1;
        n = obs_q.size();
        tests++; if (n != 2 * N) begin fails++; $display("FAIL bp_count: got %0d beats required %0d", n, 2 * N); end
        for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            ob = obs_q.pop_front();
            eb = exp_q.pop_front();
            tests++;
            if (ob.data !== eb.data || ob.last !== eb.last || ob.id !== eb.id) begin
                fails++; $display("FAIL bp_beat %0d: got %h last %b required %h last %b", k, ob.data, ob.last, eb.data, eb.last);
            end
        end
    endtask

    task automatic test_random();
        beat_t ob;
        beat_t eb;
        int    n;
        int    w = 0;
        rdy_mode = 2;
        for (int b = 0; b < 20; b++) send_block(1, 1'b1);
        in_ch.t_valid = 1'b0;
        rdy_mode = 1;
        while (obs_q.size() < 20 * N && w < 1000) begin
            @(posedge aclk);
            w++;
        end
        repeat (4) @(posedge aclk);
        #1;
        n = obs_q.size();
        tests++; if (n != 20 * N || exp_q.size() != 20 * N) begin
            fails++; $display("FAIL rand_count: got %0d observed %0d expected-queue required %0d", n, exp_q.size(), 20 * N);
        end
        for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            ob = obs_q.pop_front();
            eb = exp_q.pop_front();
            tests++;
            if (ob.data !== eb.data || ob.last !== eb.last || ob.id !== eb.id || ob.dest !== eb.dest || ob.user !== eb.user) begin
                fails++; $display("FAIL rand_beat %0d: got %h last %b id %h required %h last %b id %h", k, ob.data, ob.last, ob.id, eb.data, eb.last, eb.id);
            end
        end
        obs_q.delete();
        exp_q.delete();
`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
        tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL rand_err: got %b required 0", err8); end
`endif
    endtask

    task automatic test_reset_mid_block();
        beat_t ob;
        beat_t eb;
        int    n;
        rdy_mode = 0;
        repeat (2) @(posedge aclk);
        #1;
        send_block(1, 1'b0);
        for (int r = 0; r < 3; r++) send_row({4{$urandom}}, 4'(r), 1'b0, 1'b0);
        in_ch.t_valid = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        tests++; if (out_ch.t_valid !== 1'b0 || in_ch.t_ready !== 1'b0) begin
            fails++; $display("FAIL midrst_during: valid %b ready %b required 0 0", out_ch.t_valid, in_ch.t_ready);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        rdy_mode = 1;
        @(negedge aclk);
        tests++; if (out_ch.t_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid: got %b required 0", out_ch.t_valid); end
        tests++; if (in_ch.t_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b required 1", in_ch.t_ready); end
        @(posedge aclk);
        #1;
        send_block(1, 1'b0);
        in_ch.t_valid = 1'b0;
        repeat (12) @(posedge aclk);
        #1;
        n = obs_q.size();
        tests++; if (n != N) begin fails++; $display("FAIL midrst_count: got %0d beats required %0d", n, N); end
        for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            ob = obs_q.pop_front();
            eb = exp_q.pop_front();
            tests++;
            if (ob.data !== eb.data || ob.last !== eb.last || ob.id !== eb.id) begin
                fails++; $display("FAIL midrst_beat %0d: got %h required %h", k, ob.data, eb.data);
            end
        end
    endtask

`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
    task automatic send4(input logic [DW4-1:0] d, input logic last);
        int n = 0;
        in4.t_valid = 1'b1;
        in4.t_data  = d;
        in4.t_last  = last;
        @(negedge aclk);
        while (!in4.t_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL send4_timeout: t_ready stayed %b, required 1", in4.t_ready);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_last_check();
        logic [DW4-1:0] r4 [N4];
        logic [DW4-1:0] col;
        for (int r = 0; r < 3; r++) send4(DW4'({$urandom, $urandom}), r == 2);
        in4.t_valid = 1'b0;
        @(negedge aclk);
        tests++; if (err4 !== 1'b1) begin fails++; $display("FAIL lc_err_set: got %b required 1", err4); end
        repeat (8) @(posedge aclk);
        #1;
        for (int r = 0; r < N4; r++) begin
            r4[r] = DW4'({$urandom, $urandom});
            send4(r4[r], r == N4 - 1);
        end
        in4.t_valid = 1'b0;
        for (int k = 0; k < N4; k++) begin
            @(negedge aclk);
            col = '0;
            for (int i = 0; i < N4; i++) col[i*CW4 +: CW4] = r4[i][k*CW4 +: CW4];
            tests++;
            if (out4.t_valid !== 1'b1 || out4.t_data !== col || out4.t_last !== (k == N4 - 1)) begin
                fails++; $display("FAIL lc_beat %0d: valid %b data %h last %b required data %h", k, out4.t_valid, out4.t_data, out4.t_last, col);
            end
        end
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        tests++; if (err4 !== 1'b0) begin fails++; $display("FAIL lc_err_clear: got %b required 0", err4); end
        @(posedge aclk);
        #1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_ch.t_valid  = 1'b0;
        in_ch.t_data   = '0;
        in_ch.t_keep   = '1;
        in_ch.t_strb   = '1;
        in_ch.t_last   = 1'b0;
        in_ch.t_id     = '0;
        in_ch.t_dest   = '0;
        in_ch.t_user   = '0;
        out_ch.t_ready = 1'b0;
`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
        in4.t_valid  = 1'b0;
        in4.t_data   = '0;
        in4.t_keep   = '1;
        in4.t_strb   = '1;
        in4.t_last   = 1'b0;
        in4.t_id     = 4'h3;
        in4.t_dest   = 4'h6;
        in4.t_user   = 4'h9;
        out4.t_ready = 1'b1;
`endif
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_block();
`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
        test_last_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
